rotate_checker: RTL and testbench

- Decides whether the active tile can rotate one step clockwise; drives rotate_avail_i of the rotate executor.
- On a request it fetches the 4x4 shape bitmap for {type, angle+1} from the shape ROM.
- It then reads the up to four map-memory rows under that bitmap, and reports avail/not-avail with a one-cycle valid pulse.
- Sits between the input decoder (request source) and the rotate executor.

---
 rtl/rotate_checker.sv | 172 +++++++++++++++++
 tb/tb_rotate_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_checker.sv
// ============================================================================
//  Module   : rotate_checker
//  Purpose  : Decides whether the active tile may rotate one step clockwise by
//             probing the rotated shape against the board rows beneath it.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package rotate_checker_pkg;
    typedef enum logic [2:0] {
        eNon = 3'd0, eI, eJ, eL, eO, eS, eT, eZ
    } tile_type_e;

    localparam int c_POS_W = 8;

    typedef struct packed {
        logic [c_POS_W-1:0] x_m;
        logic [c_POS_W-1:0] y_m;
    } point_t;
endpackage

module rotate_checker
    import rotate_checker_pkg::*;
#(
    parameter int width_p  = 16,
    parameter int height_p = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          v_i,
    output logic                          ready_o,
    input  tile_type_e                    type_i,
    input  logic [1:0]                    angle_i,
    input  point_t                        pos_i,
    output logic [$bits(tile_type_e)+1:0] rom_addr_o,
    input  logic [15:0]                   rom_data_i,
    output logic                          mm_r_v_o,
    output logic [$clog2(height_p)-1:0]   mm_addr_y_o,
    input  logic [width_p-1:0]            mm_data_i,
    output logic                          v_o,
    output logic                          avail_o
);

    localparam int c_CW   = c_POS_W + 1;
    localparam int c_AY_W = $clog2(height_p);
    localparam logic [c_CW-1:0] c_HEIGHT = c_CW'(height_p);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_ROM  = 3'd1;
    localparam logic [2:0] c_S_LOAD = 3'd2;
    localparam logic [2:0] c_S_ROW  = 3'd3;
    localparam logic [2:0] c_S_CMP  = 3'd4;
    localparam logic [2:0] c_S_DONE = 3'd5;

    logic [2:0]  r_state;
    tile_type_e  r_type;
    logic [1:0]  r_angle;
    point_t      r_pos;
    logic        r_fail;
    logic [15:0] r_shape;
    logic [1:0]  r_row;
    logic        r_avail;

    logic [3:0]      w_nib;
    logic [c_CW-1:0] w_y;
    logic            w_y_oob;
    logic [3:0]      w_hit;
    logic            w_conflict;
    logic            w_read;

    assign w_nib      = r_shape[{r_row, 2'b00} +: 4];
    assign w_y        = {1'b0, r_pos.y_m} + c_CW'(r_row);
    assign w_y_oob    = (w_y >= c_HEIGHT);
    assign w_read     = (r_state == c_S_ROW) && (w_nib != 4'd0) && !w_y_oob;
    assign w_conflict = |w_hit;

    // Cells past the right edge count as occupied; the row is never indexed
    // outside its width.
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [c_CW-1:0] w_cx;
        logic            w_occ;

        assign w_cx = {1'b0, r_pos.x_m} + c_CW'(c);

        always_comb begin
            w_occ = 1'b1;
            for (int x = 0; x < width_p; x++) begin
                if (w_cx == c_CW'(x)) begin
                    w_occ = mm_data_i[x];
                end
            end
        end

        assign w_hit[c] = w_nib[c] & w_occ;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_S_IDLE;
            r_type  <= eNon;
            r_angle <= 2'd0;
            r_pos   <= '0;
            r_fail  <= 1'b0;
            r_shape <= 16'd0;
            r_row   <= 2'd0;
            r_avail <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (v_i) begin
                        r_type  <= type_i;
                        r_angle <= angle_i + 2'd1;
                        r_pos   <= pos_i;
                        r_fail  <= 1'b0;
                        r_state <= c_S_ROM;
                    end
                end
                c_S_ROM: begin
                    r_state <= c_S_LOAD;
                end
                c_S_LOAD: begin
                    r_shape <= rom_data_i;
                    r_row   <= 2'd0;
                    r_state <= c_S_ROW;
                end
                c_S_ROW: begin
                    if (w_nib == 4'd0) begin
                        if (r_row == 2'd3) begin
                            r_state <= c_S_DONE;
                        end else begin
                            r_row <= r_row + 2'd1;
                        end
                    end else if (w_y_oob) begin
                        r_fail  <= 1'b1;
                        r_state <= c_S_DONE;
                    end else begin
                        r_state <= c_S_CMP;
                    end
                end
                c_S_CMP: begin
                    if (w_conflict) begin
                        r_fail  <= 1'b1;
                        r_state <= c_S_DONE;
                    end else if (r_row == 2'd3) begin
                        r_state <= c_S_DONE;
                    end else begin
                        r_row   <= r_row + 2'd1;
                        r_state <= c_S_ROW;
                    end
                end
                c_S_DONE: begin
                    r_avail <= ~r_fail;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign ready_o     = (r_state == c_S_IDLE);
    assign rom_addr_o  = {r_type, r_angle};
    assign mm_r_v_o    = w_read;
    assign mm_addr_y_o = w_y[c_AY_W-1:0];
    assign v_o         = (r_state == c_S_DONE);
    // Result shows together with the valid pulse, then is held by r_avail.
    assign avail_o     = (r_state == c_S_DONE) ? ~r_fail : r_avail;

endmodule

`default_nettype wire

// File: tb/tb_rotate_checker.sv
// ============================================================================
//  Module   : tb_rotate_checker
//  Purpose  : Randomised and directed scoreboard bench for rotate_checker.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rotate_checker;
    import rotate_checker_pkg::*;

    localparam int W = 16;
    localparam int H = 32;

    logic        clk;
    logic        reset_i;
    logic        v_i;
    logic        ready_o;
    tile_type_e  type_i;
    logic [1:0]  angle_i;
    point_t      pos_i;
    logic [4:0]  rom_addr_o;
    logic [15:0] rom_data;
    logic        mm_r_v_o;
    logic [4:0]  mm_addr_y_o;
    logic [15:0] mm_data;
    logic        v_o;
    logic        avail_o;

    rotate_checker #(.width_p(W), .height_p(H)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .type_i      (type_i),
        .angle_i     (angle_i),
        .pos_i       (pos_i),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data),
        .mm_r_v_o    (mm_r_v_o),
        .mm_addr_y_o (mm_addr_y_o),
        .mm_data_i   (mm_data),
        .v_o         (v_o),
        .avail_o     (avail_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rom_tab [0:31];
    logic [15:0] map     [0:H-1];

    always @(posedge clk) rom_data <= rom_tab[rom_addr_o];
    always @(posedge clk) if (mm_r_v_o) mm_data <= map[mm_addr_y_o];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int avail; int at; } res_t;
    res_t res_q[$];
    int   rd_q[$];
    res_t e;
    int   held = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: walk the four shape rows, applying the skip/bound/collision rules.
    task automatic model_push(input int t, input int a, input int x, input int y);
        int shape, nib, lat, ok;
        shape = int'(rom_tab[t*4 + ((a + 1) % 4)]);
        lat = 3;
        ok  = 1;
        for (int r = 0; r < 4; r++) begin
            nib = (shape >> (4*r)) & 15;
            if (nib == 0) begin
                lat += 1;
                continue;
            end
            if (y + r >= H) begin
                ok = 0;
                lat += 1;
                break;
            end
            rd_q.push_back(y + r);
            lat += 2;
            for (int c = 0; c < 4; c++)
                if (((nib >> c) & 1) != 0)
                    if (x + c >= W || map[y+r][x+c] == 1'b1) ok = 0;
            if (ok == 0) break;
        end
        res_q.push_back('{avail: ok, at: cyc + lat});
    endtask

    always @(negedge clk) begin
        if (mm_r_v_o) begin
            if (rd_q.size() == 0) chk("unexpected_read", int'(mm_addr_y_o), -1);
            else chk("read_row", int'(mm_addr_y_o), rd_q.pop_front());
        end
        if (v_o) begin
            if (res_q.size() == 0) chk("unexpected_v_o", 1, 0);
            else begin
                e = res_q.pop_front();
                chk("v_o_cycle", cyc, e.at);
                chk("avail", int'(avail_o), e.avail);
                held = e.avail;
            end
        end
    end

    task automatic run_req(input int t, input int a, input int x, input int y, input bit poke);
        int waitc;
        @(negedge clk);
        chk("ready_idle", int'(ready_o), 1);
        chk("avail_hold", int'(avail_o), held);
        type_i  = tile_type_e'(3'(t));
        angle_i = 2'(a);
        pos_i.x_m = 8'(x);
        pos_i.y_m = 8'(y);
        v_i = 1'b1;
        model_push(t, a, x, y);
        @(negedge clk);
        v_i = 1'b0;
        chk("rom_addr", int'(rom_addr_o), t*4 + ((a + 1) % 4));
        chk("busy", int'(ready_o), 0);
        if (poke) begin
            repeat (2) @(negedge clk);
            type_i    = eI;
            pos_i     = '0;
            v_i       = 1'b1;
            chk("busy_poke", int'(ready_o), 0);
            @(negedge clk);
            v_i = 1'b0;
        end
        waitc = 0;
        while (res_q.size() > 0 && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        if (res_q.size() > 0) begin
            chk("timeout", 0, 1);
            res_q.delete();
            rd_q.delete();
        end
    endtask

    task automatic rand_tables();
        for (int i = 0; i < 32; i++) begin
            int v;
            v = 0;
            if (i >= 4)
                for (int n = 0; n < 4; n++)
                    if ($urandom_range(0, 2) != 0) v |= $urandom_range(1, 15) << (4*n);
            rom_tab[i] = 16'(v);
        end
        for (int r = 0; r < H; r++)
            map[r] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
    endtask

    task automatic clear_map();
        for (int r = 0; r < H; r++) map[r] = 16'h0;
    endtask

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b0;
        type_i  = eNon;
        angle_i = 2'd0;
        pos_i   = '0;
        for (int i = 0; i < 32; i++) rom_tab[i] = 16'h0;
        clear_map();
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        chk("rst_ready", int'(ready_o), 1);
        chk("rst_v_o", int'(v_o), 0);
        chk("rst_avail", int'(avail_o), 0);
        chk("rst_mm_r_v", int'(mm_r_v_o), 0);
        chk("rst_rom_addr", int'(rom_addr_o), 0);

        // Directed: type eT, angle 3 wraps to ROM slot {eT,0} = 24.
        rom_tab[24] = 16'h2222;
        run_req(6, 3, 4, 4, 1'b0);
        map[6][5] = 1'b1;
        run_req(6, 3, 4, 4, 1'b0);
        clear_map();
        rom_tab[24] = 16'h000F;
        run_req(6, 3, 14, 0, 1'b0);
        rom_tab[24] = 16'h2222;
        run_req(6, 3, 0, 30, 1'b0);
        run_req(6, 3, 4, 4, 1'b1);
        run_req(0, 1, 5, 5, 1'b0);
        rom_tab[24] = 16'h0F00;
        run_req(6, 3, 2, 3, 1'b0);

        // Reset asserted in cycle 5 of a check that only reads row 5 (in cycle 5).
        @(negedge clk);
        type_i = eT; angle_i = 2'd3; pos_i.x_m = 8'd2; pos_i.y_m = 8'd3;
        v_i = 1'b1;
        rd_q.push_back(5);
        @(negedge clk);
        v_i = 1'b0;
        repeat (4) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        chk("midrst_ready", int'(ready_o), 1);
        chk("midrst_avail", int'(avail_o), 0);
        chk("midrst_v_o", int'(v_o), 0);
        chk("midrst_rom_addr", int'(rom_addr_o), 0);
        held = 0;
        repeat (15) @(negedge clk);

        for (int k = 0; k < 150; k++) begin
            if (k % 25 == 0) rand_tables();
            run_req($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 17),
                    $urandom_range(0, 33), $urandom_range(0, 9) == 0);
        end

        repeat (5) @(negedge clk);
        chk("reads_drained", rd_q.size(), 0);
        chk("results_drained", res_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
